i2c_slave_reg_bridge: RTL and testbench

Parametrised command engine between the CDC command/upload buses and an I2C-slave register file of configurable depth.
- Executes three opcodes: set-slave-address, burst-write and burst-read.
- Burst length is arbitrary; register addresses wrap modulo the register depth.
- Talks to the register file over a generic synchronous port (1-cycle read latency) and owns the 7-bit slave address register.

---
 rtl/i2c_slave_pkg.sv | 27 ++
 rtl/i2c_slave_payload_buf.sv | 74 +++++++
 rtl/i2c_slave_reg_bridge.sv | 149 ++++++++++++++
 tb/tb_i2c_slave_reg_bridge.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared types and default constants for the I2C slave register bridge.
// Opcodes and the reset slave address live here so the top and the bench agree.
package i2c_slave_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SET_ADDR,
        ST_WRITE,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_UPLOAD,
        ST_FINISH
    } state_t;

    localparam byte_t      DEF_CMD_SET_ADDR = 8'h34;
    localparam byte_t      DEF_CMD_WRITE    = 8'h35;
    localparam byte_t      DEF_CMD_READ     = 8'h36;
    localparam logic [6:0] DEF_SLAVE_ADDR   = 7'h24;

    function automatic byte_t min8(input byte_t a, input byte_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/i2c_slave_payload_buf.sv
// Command payload capture: addr/len header latch, write-data buffer,
// received-byte counter and a once-per-command overflow pulse.
module i2c_slave_payload_buf
    import i2c_slave_pkg::*;
#(
    parameter int MAX_WR_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        capture,
    input  logic [7:0]  data,
    input  logic [15:0] index,
    input  logic [7:0]  rd_idx,
    output logic [7:0]  start_addr,
    output logic [7:0]  len,
    output logic [7:0]  rx_cnt,
    output logic [7:0]  eff_len,
    output logic [7:0]  eff_cnt,
    output logic [7:0]  rd_byte,
    output logic        err_overflow
);

    localparam int          BUF_AW  = (MAX_WR_BYTES > 1) ? $clog2(MAX_WR_BYTES) : 1;
    localparam logic [15:0] PAY_END = 16'(MAX_WR_BYTES + 2);
    localparam logic [7:0]  CNT_MAX = 8'(MAX_WR_BYTES);

    byte_t       mem [MAX_WR_BYTES];
    logic        ovf_seen;
    logic [15:0] offset;
    logic        in_payload;
    logic        beyond;
    logic        unused_bits;

    assign offset      = index - 16'd2;
    assign in_payload  = capture && (index >= 16'd2) && (index < PAY_END);
    assign beyond      = capture && (index >= PAY_END);
    assign unused_bits = ^{offset[15:BUF_AW], rd_idx[7:BUF_AW]};

    // Header/count values as they will be once this cycle's byte is stored, so a
    // cmd_done coinciding with the last byte decodes against complete data.
    assign eff_len = (capture && index == 16'd1) ? data : len;
    assign eff_cnt = (in_payload && rx_cnt != CNT_MAX) ? rx_cnt + 8'd1 : rx_cnt;
    assign rd_byte = mem[rd_idx[BUF_AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload buffer is reset explicitly because stale bytes
            // must never leak into a later burst; this is a small flop array, not RAM.
            for (int k = 0; k < MAX_WR_BYTES; k++) mem[k] <= '0;
            start_addr   <= '0;
            len          <= '0;
            rx_cnt       <= '0;
            ovf_seen     <= 1'b0;
            err_overflow <= 1'b0;
        end else if (clear) begin
            start_addr   <= '0;
            len          <= '0;
            rx_cnt       <= '0;
            ovf_seen     <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_overflow <= beyond && !ovf_seen;
            if (beyond) ovf_seen <= 1'b1;
            if (capture && index == 16'd0) start_addr <= data;
            if (capture && index == 16'd1) len <= data;
            if (in_payload) begin
                mem[offset[BUF_AW-1:0]] <= data;
                if (rx_cnt != CNT_MAX) rx_cnt <= rx_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_slave_reg_bridge.sv
// Command engine: set-slave-address, burst write and burst read between the
// command/upload buses and a synchronous I2C-slave register file.
module i2c_slave_reg_bridge
    import i2c_slave_pkg::*;
#(
    parameter int         REG_DEPTH          = 16,
    parameter int         MAX_WR_BYTES       = 32,
    parameter logic [7:0] CMD_SET_ADDR       = DEF_CMD_SET_ADDR,
    parameter logic [7:0] CMD_WRITE          = DEF_CMD_WRITE,
    parameter logic [7:0] CMD_READ           = DEF_CMD_READ,
    parameter logic [6:0] DEFAULT_SLAVE_ADDR = DEF_SLAVE_ADDR,
    localparam int        ADDR_W             = $clog2(REG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        cmd_type,
    input  logic [15:0]       cmd_length,
    input  logic [7:0]        cmd_data,
    input  logic [15:0]       cmd_data_index,
    input  logic              cmd_start,
    input  logic              cmd_data_valid,
    input  logic              cmd_done,
    output logic              cmd_ready,
    output logic              upload_active,
    output logic              upload_req,
    output logic [7:0]        upload_data,
    output logic [7:0]        upload_source,
    output logic              upload_valid,
    input  logic              upload_ready,
    output logic [6:0]        slave_addr,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    input  logic [7:0]        reg_rdata,
    output logic              err_overflow
);

    state_t      state, state_nxt;
    byte_t       opcode;
    byte_t       idx;
    byte_t       hold;
    byte_t       start_addr, len, rx_cnt, eff_len, eff_cnt, rd_byte;
    byte_t       wr_n, wr_n_eff;
    logic        valid_op, restart, capture;
    logic [ADDR_W-1:0] cur_addr;
    logic        unused_bits;

    assign valid_op = (cmd_type == CMD_SET_ADDR) || (cmd_type == CMD_WRITE) ||
                      (cmd_type == CMD_READ);
    assign restart  = cmd_start && ((state == ST_IDLE && valid_op) || state == ST_CAPTURE);
    assign capture  = (state == ST_CAPTURE) && cmd_data_valid && !cmd_start;
    assign wr_n     = min8(len, rx_cnt);
    assign wr_n_eff = min8(eff_len, eff_cnt);
    assign cur_addr = start_addr[ADDR_W-1:0] + idx[ADDR_W-1:0];
    assign upload_source = CMD_READ;
    assign unused_bits   = ^{cmd_length, start_addr[7]};

    i2c_slave_payload_buf #(.MAX_WR_BYTES(MAX_WR_BYTES)) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (restart),
        .capture     (capture),
        .data        (cmd_data),
        .index       (cmd_data_index),
        .rd_idx      (idx),
        .start_addr  (start_addr),
        .len         (len),
        .rx_cnt      (rx_cnt),
        .eff_len     (eff_len),
        .eff_cnt     (eff_cnt),
        .rd_byte     (rd_byte),
        .err_overflow(err_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb assigns a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (cmd_start && valid_op) state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                if (cmd_start) begin
                    state_nxt = valid_op ? ST_CAPTURE : ST_IDLE;
                end else if (cmd_done) begin
                    if (opcode == CMD_SET_ADDR)   state_nxt = ST_SET_ADDR;
                    else if (opcode == CMD_WRITE) state_nxt = (wr_n_eff == 8'd0) ? ST_FINISH : ST_WRITE;
                    else if (opcode == CMD_READ)  state_nxt = (eff_len == 8'd0) ? ST_FINISH : ST_RD_ADDR;
                    else                          state_nxt = ST_IDLE;
                end
            end
            ST_SET_ADDR: state_nxt = ST_FINISH;
            ST_WRITE:    if ({1'b0, idx} + 9'd1 >= {1'b0, wr_n}) state_nxt = ST_FINISH;
            ST_RD_ADDR:  state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:  state_nxt = ST_UPLOAD;
            ST_UPLOAD:   if (upload_ready) state_nxt = (idx + 8'd1 == len) ? ST_FINISH : ST_RD_ADDR;
            ST_FINISH:   state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = (state == ST_IDLE) || (state == ST_CAPTURE);
        upload_req    = 1'b0;
        upload_active = 1'b0;
        upload_data   = '0;
        upload_valid  = 1'b0;
        reg_addr      = '0;
        reg_wdata     = '0;
        reg_we        = 1'b0;
        case (state)
            ST_WRITE: begin
                reg_we    = 1'b1;
                reg_addr  = cur_addr;
                reg_wdata = rd_byte;
            end
            ST_RD_ADDR: reg_addr = cur_addr;
            ST_UPLOAD: begin
                upload_req    = 1'b1;
                upload_active = 1'b1;
                upload_data   = hold;
                upload_valid  = upload_ready;
            end
            default: ;
        endcase
    end

    // Byte counter, read hold register, opcode latch and slave address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode     <= '0;
            idx        <= '0;
            hold       <= '0;
            slave_addr <= DEFAULT_SLAVE_ADDR;
        end else begin
            if (restart && valid_op) opcode <= cmd_type;
            if (state == ST_CAPTURE)                     idx <= '0;
            else if (state == ST_WRITE)                  idx <= idx + 8'd1;
            else if (state == ST_UPLOAD && upload_ready) idx <= idx + 8'd1;
            if (state == ST_RD_WAIT)  hold <= reg_rdata;
            if (state == ST_SET_ADDR) slave_addr <= start_addr[6:0];
        end
    end

endmodule

// File: tb/tb_i2c_slave_reg_bridge.sv
// Directed bench for i2c_slave_reg_bridge with a 1-cycle-latency register file model.
module tb_i2c_slave_reg_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cmd_type;
    logic [15:0] cmd_length;
    logic [7:0]  cmd_data;
    logic [15:0] cmd_data_index;
    logic        cmd_start, cmd_data_valid, cmd_done;
    logic        cmd_ready, upload_active, upload_req, upload_valid, upload_ready;
    logic [7:0]  upload_data, upload_source;
    logic [6:0]  slave_addr;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_wdata, reg_rdata;
    logic        reg_we, err_overflow;

    i2c_slave_reg_bridge dut (
        .clk(clk), .rst_n(rst_n), .cmd_type(cmd_type), .cmd_length(cmd_length),
        .cmd_data(cmd_data), .cmd_data_index(cmd_data_index), .cmd_start(cmd_start),
        .cmd_data_valid(cmd_data_valid), .cmd_done(cmd_done), .cmd_ready(cmd_ready),
        .upload_active(upload_active), .upload_req(upload_req), .upload_data(upload_data),
        .upload_source(upload_source), .upload_valid(upload_valid), .upload_ready(upload_ready),
        .slave_addr(slave_addr), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_rdata(reg_rdata), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt = 0;
    int done_cyc;
    int ovf_cnt = 0;
    logic [7:0] regs [16];
    logic [7:0] pl [$];
    logic [3:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int         wr_cyc_q [$];
    logic [7:0] up_q [$];
    logic [7:0] src_q [$];

    logic [3:0] exp_wa [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    logic [7:0] exp_wd [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] exp_rd [3] = '{8'h11, 8'h22, 8'h33};

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(posedge clk) begin
        if (reg_we) regs[reg_addr] <= reg_wdata;
        reg_rdata <= regs[reg_addr];
    end

    always @(posedge clk) begin
        if (reg_we) begin
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
            wr_cyc_q.push_back(cyc_cnt);
        end
        if (upload_valid) begin
            up_q.push_back(upload_data);
            src_q.push_back(upload_source);
        end
        if (err_overflow) ovf_cnt <= ovf_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Sends opcode + pl[]; cmd_done either rides on the last byte or follows it.
    task automatic send_cmd(input logic [7:0] op, input bit done_same);
        cmd_type   = op;
        cmd_length = 16'(pl.size());
        cmd_start  = 1'b1;
        cyc();
        cmd_start = 1'b0;
        for (int k = 0; k < pl.size(); k++) begin
            cmd_data_valid = 1'b1;
            cmd_data       = pl[k];
            cmd_data_index = 16'(k);
            if (done_same && k == pl.size() - 1) begin
                cmd_done = 1'b1;
                done_cyc = cyc_cnt;
            end
            cyc();
        end
        cmd_data_valid = 1'b0;
        if (!done_same || pl.size() == 0) begin
            cmd_done = 1'b1;
            done_cyc = cyc_cnt;
            cyc();
        end
        cmd_done = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            cyc();
            n++;
        end
        check(tag, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int wb, ub, ob, n;
        rst_n = 1'b0;
        cmd_type = '0; cmd_length = '0; cmd_data = '0; cmd_data_index = '0;
        cmd_start = 1'b0; cmd_data_valid = 1'b0; cmd_done = 1'b0; upload_ready = 1'b0;
        for (int k = 0; k < 16; k++) regs[k] = '0;
        repeat (3) cyc();
        check("rst_src_in_reset", 32'(upload_source), 32'h36);
        rst_n = 1'b1;
        cyc();
        check("rst_slave_addr", 32'(slave_addr), 32'h24);
        check("rst_reg_we", 32'(reg_we), 32'd0);
        check("rst_upload_req", 32'(upload_req), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_err_ovf", 32'(err_overflow), 32'd0);

        // Set slave address: visible two cycles after cmd_done.
        wb = wr_addr_q.size();
        pl = '{8'h5A};
        send_cmd(8'h34, 1'b0);
        check("sa_t1_old", 32'(slave_addr), 32'h24);
        check("sa_t1_busy", 32'(cmd_ready), 32'd0);
        cyc();
        check("sa_t2_new", 32'(slave_addr), 32'h5A);
        wait_ready("sa_ready");
        check("sa_no_we", 32'(wr_addr_q.size() - wb), 32'd0);

        // Unknown opcode is ignored entirely.
        pl = '{8'h00, 8'h01, 8'hEE};
        send_cmd(8'h99, 1'b0);
        repeat (4) cyc();
        check("badop_no_we", 32'(wr_addr_q.size() - wb), 32'd0);

        // Wrapping burst write, cmd_done with the last byte.
        wb = wr_addr_q.size();
        pl = '{8'h0E, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_cmd(8'h35, 1'b1);
        wait_ready("wr_ready");
        check("wr_count", 32'(wr_addr_q.size() - wb), 32'd4);
        if (wr_addr_q.size() - wb >= 4)
            for (int k = 0; k < 4; k++) begin
                check("wr_addr", 32'(wr_addr_q[wb+k]), 32'(exp_wa[k]));
                check("wr_data", 32'(wr_data_q[wb+k]), 32'(exp_wd[k]));
                check("wr_cycle", 32'(wr_cyc_q[wb+k]), 32'(done_cyc + 1 + k));
            end

        // Preload registers 2..4 then read them back with a toggling sink.
        pl = '{8'h02, 8'h03, 8'h11, 8'h22, 8'h33};
        send_cmd(8'h35, 1'b0);
        wait_ready("pre_ready");
        wb = wr_addr_q.size();
        ub = up_q.size();
        pl = '{8'h02, 8'h03};
        send_cmd(8'h36, 1'b0);
        n = 0;
        while (up_q.size() - ub < 3 && n < 80) begin
            if (upload_req) check("rd_hold", 32'(upload_data), 32'(exp_rd[up_q.size() - ub]));
            upload_ready = ~upload_ready;
            cyc();
            n++;
        end
        upload_ready = 1'b0;
        check("rd_count", 32'(up_q.size() - ub), 32'd3);
        if (up_q.size() - ub >= 3)
            for (int k = 0; k < 3; k++) begin
                check("rd_data", 32'(up_q[ub+k]), 32'(exp_rd[k]));
                check("rd_src", 32'(src_q[ub+k]), 32'h36);
            end
        wait_ready("rd_ready");
        check("rd_no_we", 32'(wr_addr_q.size() - wb), 32'd0);

        // Oversized write: 32 strobes, one overflow pulse.
        wb = wr_addr_q.size();
        ob = ovf_cnt;
        pl.delete();
        pl.push_back(8'h00);
        pl.push_back(8'd40);
        for (int k = 0; k < 38; k++) pl.push_back(8'(k + 1));
        send_cmd(8'h35, 1'b0);
        wait_ready("ovf_ready");
        cyc();
        check("ovf_pulses", 32'(ovf_cnt - ob), 32'd1);
        check("ovf_writes", 32'(wr_addr_q.size() - wb), 32'd32);
        if (wr_addr_q.size() - wb >= 32) begin
            check("ovf_last_addr", 32'(wr_addr_q[wb+31]), 32'd15);
            check("ovf_last_data", 32'(wr_data_q[wb+31]), 32'h20);
            check("ovf_first_data", 32'(wr_data_q[wb]), 32'h01);
        end

        // len=0 write: FINISH directly, no strobe.
        wb = wr_addr_q.size();
        ob = ovf_cnt;
        pl = '{8'h03, 8'h00, 8'h77, 8'h88};
        send_cmd(8'h35, 1'b0);
        check("len0_t1_busy", 32'(cmd_ready), 32'd0);
        cyc();
        check("len0_t2_idle", 32'(cmd_ready), 32'd1);
        check("len0_no_we", 32'(wr_addr_q.size() - wb), 32'd0);
        check("len0_no_ovf", 32'(ovf_cnt - ob), 32'd0);

        // len=0 read: no upload.
        ub = up_q.size();
        pl = '{8'h02, 8'h00};
        send_cmd(8'h36, 1'b0);
        check("rlen0_no_req", 32'(upload_req), 32'd0);
        wait_ready("rlen0_ready");
        check("rlen0_no_up", 32'(up_q.size() - ub), 32'd0);

        // Reset while the third upload byte is pending.
        ub = up_q.size();
        pl = '{8'h02, 8'h03};
        send_cmd(8'h36, 1'b0);
        n = 0;
        upload_ready = 1'b1;
        while (up_q.size() - ub < 2 && n < 40) begin cyc(); n++; end
        upload_ready = 1'b0;
        n = 0;
        while (!upload_req && n < 10) begin cyc(); n++; end
        check("rst_mid_pending", 32'(upload_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_req", 32'(upload_req), 32'd0);
        check("rst_mid_slave", 32'(slave_addr), 32'h24);
        upload_ready = 1'b1;
        repeat (3) cyc();
        check("rst_mid_xfers", 32'(up_q.size() - ub), 32'd2);
        rst_n = 1'b1;
        upload_ready = 1'b0;
        cyc();

        // Follow-up write and read execute normally.
        wb = wr_addr_q.size();
        pl = '{8'h01, 8'h01, 8'h5C};
        send_cmd(8'h35, 1'b0);
        wait_ready("post_wr_ready");
        check("post_wr_count", 32'(wr_addr_q.size() - wb), 32'd1);
        if (wr_addr_q.size() - wb >= 1) begin
            check("post_wr_addr", 32'(wr_addr_q[wb]), 32'd1);
            check("post_wr_data", 32'(wr_data_q[wb]), 32'h5C);
        end
        ub = up_q.size();
        pl = '{8'h01, 8'h01};
        upload_ready = 1'b1;
        send_cmd(8'h36, 1'b0);
        wait_ready("post_rd_ready");
        upload_ready = 1'b0;
        check("post_rd_count", 32'(up_q.size() - ub), 32'd1);
        if (up_q.size() - ub >= 1) check("post_rd_data", 32'(up_q[ub]), 32'h5C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
